ama_riscv_perf_trace: RTL and testbench

// Parametrised perf/trace monitor for the core. Successor to the fixed per-signal staging views.

---
 rtl/ama_riscv_perf_trace.sv | 168 ++++++++++++++++
 tb/tb_ama_riscv_perf_trace.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_perf_trace.sv
// Perf/trace monitor: retire-aligned event counters with snapshot, plus a
// retired-instruction trace FIFO under a start/stop/freeze capture FSM.
module ama_riscv_perf_trace #(
    parameter int NUM_EVT      = 8,
    parameter int CNT_W        = 32,
    parameter int SAT          = 0,
    parameter int DEPTH        = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_EVT-1:0]         evt_in,
    input  logic [NUM_EVT-1:0]         evt_en,
    input  logic                       cnt_clr,
    input  logic                       cnt_snap,
    output logic [NUM_EVT*CNT_W-1:0]   snap_cnt,
    output logic [NUM_EVT-1:0]         cnt_ovf,
    input  logic                       tr_start,
    input  logic                       tr_stop,
    input  logic                       tr_flush,
    input  logic                       tr_valid,
    input  logic [31:0]                tr_pc,
    input  logic [31:0]                tr_inst,
    input  logic [31:0]                tr_dmem_addr,
    input  logic [3:0]                 tr_dmem_size,
    output logic                       tr_out_valid,
    input  logic                       tr_out_ready,
    output logic [99:0]                tr_out_data,
    output logic [$clog2(DEPTH):0]     tr_level,
    output logic [15:0]                tr_drop_cnt,
    output logic [1:0]                 tr_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt [NUM_EVT];

    logic [99:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level, level_nxt;
    logic          full, empty, push, pop, drop;

    // Snapshot samples the pre-update counters, so a same-cycle clear or
    // increment never leaks into the captured values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVT; i++) begin
                cnt[i] <= '0;
            end
            cnt_ovf  <= '0;
            snap_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_EVT; i++) begin
                if (cnt_snap) begin
                    snap_cnt[i*CNT_W +: CNT_W] <= cnt[i];
                end
                if (cnt_clr) begin
                    cnt[i]     <= '0;
                    cnt_ovf[i] <= 1'b0;
                end else if (evt_in[i] && evt_en[i]) begin
                    if (&cnt[i]) begin
                        cnt_ovf[i] <= 1'b1;
                        if (SAT == 0) begin
                            cnt[i] <= '0;
                        end
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign empty        = (level == '0);
    assign full         = (level == FULL_LVL);
    assign tr_out_valid = !empty;
    assign tr_out_data  = empty ? '0 : mem[rd_ptr];
    assign tr_level     = level;
    assign tr_state     = state;

    assign pop  = tr_out_valid && tr_out_ready;
    assign push = tr_valid && (state == ST_RUN) && (!full || pop) && !tr_flush;
    assign drop = tr_valid && (state == ST_RUN) && full && !pop && !tr_flush
                  && (STOP_ON_FULL == 0);

    always_comb begin
        level_nxt = level;
        if (tr_flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + (AW+1)'(1);
        end else if (pop && !push) begin
            level_nxt = level - (AW+1)'(1);
        end
    end

    // Storage has no reset: empty-gating on the read side hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tr_dmem_size, tr_dmem_addr, tr_inst, tr_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || tr_flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            tr_drop_cnt <= '0;
        end else begin
            level <= level_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop && (tr_drop_cnt != 16'hFFFF)) begin
                tr_drop_cnt <= tr_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stop always beats start; freezing looks at the occupancy after this cycle's push/pop.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!tr_stop && tr_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tr_stop) begin
                    state_nxt = ST_IDLE;
                end else if ((STOP_ON_FULL != 0) && (level_nxt == FULL_LVL)) begin
                    state_nxt = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (tr_stop) begin
                    state_nxt = ST_IDLE;
                end else if (tr_start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ama_riscv_perf_trace.sv
// Bench for ama_riscv_perf_trace: two instances (wrap/drop and saturate/freeze)
// share stimulus; trace output is checked against a record scoreboard.
module tb_ama_riscv_perf_trace;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  evt_in, evt_en;
    logic        cnt_clr, cnt_snap;
    logic        tr_start, tr_stop, tr_flush, tr_valid, tr_out_ready;
    logic [31:0] tr_pc, tr_inst, tr_dmem_addr;
    logic [3:0]  tr_dmem_size;

    logic [63:0] snap_a, snap_b;
    logic [7:0]  ovf_a, ovf_b;
    logic        valid_a, valid_b;
    logic [99:0] data_a, data_b;
    logic [4:0]  level_a, level_b;
    logic [15:0] drop_a, drop_b;
    logic [1:0]  state_a, state_b;

    logic        sel;
    wire         cur_valid = sel ? valid_b : valid_a;
    wire [99:0]  cur_data  = sel ? data_b  : data_a;
    wire [4:0]   cur_level = sel ? level_b : level_a;
    wire [15:0]  cur_drop  = sel ? drop_b  : drop_a;
    wire [1:0]   cur_state = sel ? state_b : state_a;

    int n_cmp = 0;
    int n_err = 0;
    logic [99:0] sb_q[$];

    typedef struct {
        logic [7:0] evt;
        logic [7:0] en;
        logic       clr;
        logic       snap;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } cnt_vec_t;

    cnt_vec_t vecs[10];

    always #5 clk = ~clk;

    ama_riscv_perf_trace #(.NUM_EVT(8), .CNT_W(8), .SAT(0), .DEPTH(16), .STOP_ON_FULL(0)) dut_a (
        .clk(clk), .rst(rst), .evt_in(evt_in), .evt_en(evt_en), .cnt_clr(cnt_clr),
        .cnt_snap(cnt_snap), .snap_cnt(snap_a), .cnt_ovf(ovf_a), .tr_start(tr_start),
        .tr_stop(tr_stop), .tr_flush(tr_flush), .tr_valid(tr_valid), .tr_pc(tr_pc),
        .tr_inst(tr_inst), .tr_dmem_addr(tr_dmem_addr), .tr_dmem_size(tr_dmem_size),
        .tr_out_valid(valid_a), .tr_out_ready(tr_out_ready), .tr_out_data(data_a),
        .tr_level(level_a), .tr_drop_cnt(drop_a), .tr_state(state_a)
    );

    ama_riscv_perf_trace #(.NUM_EVT(8), .CNT_W(8), .SAT(1), .DEPTH(16), .STOP_ON_FULL(1)) dut_b (
        .clk(clk), .rst(rst), .evt_in(evt_in), .evt_en(evt_en), .cnt_clr(cnt_clr),
        .cnt_snap(cnt_snap), .snap_cnt(snap_b), .cnt_ovf(ovf_b), .tr_start(tr_start),
        .tr_stop(tr_stop), .tr_flush(tr_flush), .tr_valid(tr_valid), .tr_pc(tr_pc),
        .tr_inst(tr_inst), .tr_dmem_addr(tr_dmem_addr), .tr_dmem_size(tr_dmem_size),
        .tr_out_valid(valid_b), .tr_out_ready(tr_out_ready), .tr_out_data(data_b),
        .tr_level(level_b), .tr_drop_cnt(drop_b), .tr_state(state_b)
    );

    function automatic logic [99:0] make_rec(input int k);
        logic [31:0] pc, inst, addr;
        logic [3:0]  size;
        pc   = 32'h0000_1000 + 32'(k) * 32'd4;
        inst = 32'hA5A5_0000 ^ 32'(k);
        addr = (k % 2 == 1) ? 32'h0 : 32'h8000_0000 + 32'(k) * 32'd8;
        size = (k % 2 == 1) ? 4'd8 : 4'd2;
        return {size, addr, inst, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkHead(input string name);
        if (sb_q.size() > 0) checkOutput(name, 128'(cur_data), 128'(sb_q[0]));
        else                 checkOutput(name, 128'(cur_data), 128'(0));
    endtask

    task automatic clearStrobes();
        tr_start = 1'b0; tr_stop = 1'b0; tr_flush = 1'b0;
        cnt_clr  = 1'b0; cnt_snap = 1'b0;
    endtask

    // One clock of trace stimulus; pops are scored before the edge, expected pushes queued after.
    task automatic applyStimulus(input logic valid, input int k, input logic ready, input logic expect_push);
        logic [99:0] r;
        r            = make_rec(k);
        tr_valid     = valid;
        tr_pc        = r[31:0];
        tr_inst      = r[63:32];
        tr_dmem_addr = r[95:64];
        tr_dmem_size = r[99:96];
        tr_out_ready = ready;
        if (cur_valid && tr_out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_pop", 128'(cur_data), 128'(0));
            end else begin
                checkOutput("pop_data", 128'(cur_data), 128'(sb_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        if (expect_push) sb_q.push_back(r);
        tr_valid     = 1'b0;
        tr_out_ready = 1'b0;
        clearStrobes();
    endtask

    task automatic drainAll();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 40) begin
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            guard++;
        end
        if (sb_q.size() > 0) checkOutput("drain_timeout", 128'(sb_q.size()), 128'(0));
        checkOutput("drained_valid", 128'(cur_valid), 128'(0));
        checkOutput("drained_level", 128'(cur_level), 128'(0));
        checkOutput("drained_data", 128'(cur_data), 128'(0));
    endtask

    task automatic doReset();
        rst = 1'b1;
        evt_in = '0; evt_en = '0; tr_valid = 1'b0; tr_out_ready = 1'b0;
        tr_pc = '0; tr_inst = '0; tr_dmem_addr = '0; tr_dmem_size = '0;
        clearStrobes();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic countCycle(input logic [7:0] evt, input logic clr, input logic snap);
        evt_in = evt; cnt_clr = clr; cnt_snap = snap;
        @(posedge clk);
        #1;
        evt_in = '0;
        clearStrobes();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 5; i++) vecs[i] = '{8'h01, 8'hFF, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'd5, 8'd0};
        vecs[6] = '{8'h03, 8'h01, 1'b0, 1'b1, 8'd5, 8'd0};
        vecs[7] = '{8'h02, 8'hFF, 1'b0, 1'b1, 8'd6, 8'd0};
        vecs[8] = '{8'h01, 8'hFF, 1'b1, 1'b1, 8'd6, 8'd1};
        vecs[9] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'd0, 8'd0};

        sel = 1'b0;
        doReset();
        checkOutput("rst_state_a", 128'(state_a), 128'(0));
        checkOutput("rst_state_b", 128'(state_b), 128'(0));
        checkOutput("rst_level_a", 128'(level_a), 128'(0));
        checkOutput("rst_valid_a", 128'(valid_a), 128'(0));
        checkOutput("rst_data_a", 128'(data_a), 128'(0));
        checkOutput("rst_drop_a", 128'(drop_a), 128'(0));
        checkOutput("rst_snap_a", 128'(snap_a), 128'(0));
        checkOutput("rst_ovf_b", 128'(ovf_b), 128'(0));

        for (int i = 0; i < 10; i++) begin
            evt_en = vecs[i].en;
            countCycle(vecs[i].evt, vecs[i].clr, vecs[i].snap);
            checkOutput($sformatf("vec%0d_snap_a", i), 128'(snap_a), 128'({48'b0, vecs[i].exp1, vecs[i].exp0}));
            checkOutput($sformatf("vec%0d_snap_b", i), 128'(snap_b), 128'({48'b0, vecs[i].exp1, vecs[i].exp0}));
            checkOutput($sformatf("vec%0d_ovf_a", i), 128'(ovf_a), 128'(0));
        end

        doReset();
        evt_en = 8'hFF;
        for (int i = 0; i < 255; i++) countCycle(8'h01, 1'b0, 1'b0);
        countCycle(8'h00, 1'b0, 1'b1);
        checkOutput("cnt255_a", 128'(snap_a), 128'(64'hFF));
        checkOutput("cnt255_ovf_a", 128'(ovf_a), 128'(0));
        countCycle(8'h01, 1'b0, 1'b0);
        countCycle(8'h00, 1'b0, 1'b1);
        checkOutput("wrap_cnt_a", 128'(snap_a), 128'(64'h00));
        checkOutput("wrap_ovf_a", 128'(ovf_a), 128'(8'h01));
        checkOutput("sat_cnt_b", 128'(snap_b), 128'(64'hFF));
        checkOutput("sat_ovf_b", 128'(ovf_b), 128'(8'h01));
        countCycle(8'h01, 1'b0, 1'b0);
        countCycle(8'h00, 1'b0, 1'b1);
        checkOutput("sat_hold_b", 128'(snap_b), 128'(64'hFF));
        checkOutput("wrap_one_a", 128'(snap_a), 128'(64'h01));
        countCycle(8'h01, 1'b1, 1'b0);
        checkOutput("clr_ovf_a", 128'(ovf_a), 128'(0));
        checkOutput("clr_ovf_b", 128'(ovf_b), 128'(0));
        countCycle(8'h00, 1'b0, 1'b1);
        checkOutput("clr_cnt_b", 128'(snap_b), 128'(0));

        sel = 1'b0;
        doReset();
        tr_start = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("a_run", 128'(cur_state), 128'(1));
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, k, 1'b0, 1'b1);
        for (int k = 16; k < 19; k++) applyStimulus(1'b1, k, 1'b0, 1'b0);
        checkOutput("a_full_level", 128'(cur_level), 128'(16));
        checkOutput("a_drop3", 128'(cur_drop), 128'(3));
        checkHead("a_head0");
        applyStimulus(1'b1, 100, 1'b1, 1'b1);
        checkOutput("a_pushpop_level", 128'(cur_level), 128'(16));
        checkOutput("a_pushpop_drop", 128'(cur_drop), 128'(3));
        checkHead("a_head1");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 1'b0);
            checkHead("a_head_stable");
        end
        drainAll();
        for (int k = 200; k < 203; k++) applyStimulus(1'b1, k, 1'b0, 1'b1);
        checkOutput("a_pre_flush_level", 128'(cur_level), 128'(3));
        tr_flush = 1'b1;
        applyStimulus(1'b1, 203, 1'b0, 1'b0);
        sb_q.delete();
        checkOutput("a_flush_level", 128'(cur_level), 128'(0));
        checkOutput("a_flush_drop", 128'(cur_drop), 128'(0));
        checkOutput("a_flush_valid", 128'(cur_valid), 128'(0));
        checkOutput("a_flush_state", 128'(cur_state), 128'(1));
        tr_start = 1'b1;
        tr_stop  = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("a_stop_wins", 128'(cur_state), 128'(0));
        applyStimulus(1'b1, 300, 1'b0, 1'b0);
        checkOutput("a_idle_nopush", 128'(cur_level), 128'(0));

        sel = 1'b1;
        doReset();
        tr_start = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, k, 1'b0, 1'b1);
        checkOutput("b_run_at15", 128'(cur_state), 128'(1));
        applyStimulus(1'b1, 15, 1'b0, 1'b1);
        checkOutput("b_frozen", 128'(cur_state), 128'(2));
        checkOutput("b_full_level", 128'(cur_level), 128'(16));
        for (int k = 16; k < 18; k++) applyStimulus(1'b1, k, 1'b0, 1'b0);
        checkOutput("b_ignored_level", 128'(cur_level), 128'(16));
        checkOutput("b_no_drop", 128'(cur_drop), 128'(0));
        checkOutput("b_still_frozen", 128'(cur_state), 128'(2));
        tr_start = 1'b1;
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("b_restart", 128'(cur_state), 128'(1));
        checkOutput("b_level15", 128'(cur_level), 128'(15));
        applyStimulus(1'b1, 50, 1'b0, 1'b1);
        checkOutput("b_push_after_restart", 128'(cur_level), 128'(16));
        checkOutput("b_refrozen", 128'(cur_state), 128'(2));
        drainAll();
        tr_start = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 60, 1'b0, 1'b1);
        applyStimulus(1'b1, 61, 1'b0, 1'b1);
        checkOutput("b_mid_level", 128'(cur_level), 128'(2));
        doReset();
        checkOutput("b_midrst_level", 128'(cur_level), 128'(0));
        checkOutput("b_midrst_valid", 128'(cur_valid), 128'(0));
        checkOutput("b_midrst_state", 128'(cur_state), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
